pulse_hold_mc: RTL



---
 rtl/pulse_hold_mc.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pulse_hold_mc.sv
// pulse_hold_mc: multi-channel pulse stretcher, hold length latched per pulse, optional retrigger.
// Define PULSE_HOLD_MC_STAT_EN to build saturating per-channel accepted-pulse counters.
module pulse_hold_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int RETRIG = 1,
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        pulse_in,
  input  logic [NUM_CH*CNT_W-1:0]  hold_num,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        pulse_out,
  output logic [NUM_CH-1:0]        busy,
  input  logic                     stat_clr,
  output logic [NUM_CH*STAT_W-1:0] stat_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD
  } state_e;

  logic [NUM_CH-1:0] pulse_r;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] accept;

  // pulse_r keeps tracking even while a channel is disabled, so a level that is
  // already high at enable time never looks like a fresh edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_r <= '0;
    else        pulse_r <= pulse_in;
  end

  assign rise = pulse_in & ~pulse_r;
  assign fall = ~pulse_in & pulse_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] hold_lat;
    logic [CNT_W-1:0] hold_lat_nxt;
    logic [CNT_W-1:0] hold_i;
    logic             expire;
    logic             acc;
    logic             out_q;
    logic             busy_q;

    assign hold_i = hold_num[i*CNT_W +: CNT_W];
    // Compare before incrementing: an all-ones hold never needs the counter to wrap.
    assign expire = (cnt == hold_lat - CNT_W'(1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      hold_lat_nxt = hold_lat;
      acc          = 1'b0;
      if (!ch_en[i]) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise[i]) begin
              state_nxt    = ACTIVE;
              hold_lat_nxt = hold_i;
              acc          = 1'b1;
            end
          end
          ACTIVE: begin
            if (fall[i]) begin
              cnt_nxt   = '0;
              state_nxt = (hold_lat == '0) ? IDLE : HOLD;
            end
          end
          HOLD: begin
            // A retrigger edge wins over expiry in the same cycle.
            if (rise[i] && (RETRIG != 0)) begin
              state_nxt    = ACTIVE;
              hold_lat_nxt = hold_i;
              cnt_nxt      = '0;
              acc          = 1'b1;
            end else if (expire) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
          default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        cnt      <= '0;
        hold_lat <= '0;
        out_q    <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        hold_lat <= hold_lat_nxt;
        out_q    <= (state_nxt != IDLE);
        busy_q   <= (state_nxt == HOLD);
      end
    end

    assign pulse_out[i] = out_q;
    assign busy[i]      = busy_q;
    assign accept[i]    = acc;

`ifdef PULSE_HOLD_MC_STAT_EN
    logic [STAT_W-1:0] stat;

    // Clear beats a coinciding increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    stat <= '0;
      else if (stat_clr)             stat <= '0;
      else if (acc && (stat != '1))  stat <= stat + STAT_W'(1);
    end

    assign stat_cnt[i*STAT_W +: STAT_W] = stat;
`else
    assign stat_cnt[i*STAT_W +: STAT_W] = '0;
`endif
  end

`ifndef PULSE_HOLD_MC_STAT_EN
  logic unused_stat;
  assign unused_stat = stat_clr ^ (^accept);
`endif

endmodule
